// File: rtl/rcu_adaptive.sv
// Route-compute unit for a 3D mesh router: deterministic ZXY or negative-first adaptive
// selection, one-cycle latency, valid/ready output register and adaptive-decision counter.
package rcu_adaptive_pkg;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } pos_t;

    // Values 0..5 double as the index into the cong vector.
    typedef enum logic [2:0] {
        DIR_NORTH = 3'd0,
        DIR_SOUTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_WEST  = 3'd3,
        DIR_UP    = 3'd4,
        DIR_DOWN  = 3'd5,
        DIR_LOCAL = 3'd6
    } dir_t;
endpackage

module rcu_adaptive
    import rcu_adaptive_pkg::*;
#(
    parameter pos_t POS    = '{x: 4'd0, y: 4'd0, z: 4'd0},
    parameter int   CONG_W = 4,
    parameter int   STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  pos_t                   in_dest,
    input  logic                   adaptive_en,
    input  logic [5:0][CONG_W-1:0] cong,
    output logic                   out_valid,
    input  logic                   out_ready,
    output dir_t                   out_dir,
    output pos_t                   out_dest,
    output logic [STAT_W-1:0]      stat_adapt,
    output logic [1:0]             dbg_rr
);
    // Handshake: a transfer happens on a side when its valid and ready are both high at
    // a rising edge; a presented result holds out_dir/out_dest stable until it transfers.
    logic              out_valid_q, out_valid_d;
    dir_t              out_dir_q, out_dir_d;
    pos_t              out_dest_q, out_dest_d;
    logic [1:0]        rr_q, rr_d;
    logic [STAT_W-1:0] stat_q, stat_d;

    logic              accept;
    logic [2:0]        neg_set, pos_set, act;
    logic              use_neg;
    dir_t              cand_dir [3];
    logic [CONG_W-1:0] cost [3];
    logic [CONG_W-1:0] min_c;
    logic [1:0]        n_min;
    logic [1:0]        rr_eff, idx, pick;
    logic [2:0]        sum;
    logic              found;
    dir_t              det_dir, adapt_dir, sel_dir;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Candidate slots are ordered by dimension: 0 = Z, 1 = X, 2 = Y.
    always_comb begin
        neg_set = {in_dest.y < POS.y, in_dest.x < POS.x, in_dest.z < POS.z};
        pos_set = {in_dest.y > POS.y, in_dest.x > POS.x, in_dest.z > POS.z};
        use_neg = |neg_set;
        act     = use_neg ? neg_set : pos_set;

        cand_dir[0] = use_neg ? DIR_DOWN  : DIR_UP;
        cand_dir[1] = use_neg ? DIR_WEST  : DIR_EAST;
        cand_dir[2] = use_neg ? DIR_SOUTH : DIR_NORTH;
        cost[0]     = use_neg ? cong[5] : cong[4];
        cost[1]     = use_neg ? cong[3] : cong[2];
        cost[2]     = use_neg ? cong[1] : cong[0];

        min_c = '1;
        for (int i = 0; i < 3; i++) begin
            if (act[i] && cost[i] < min_c) min_c = cost[i];
        end
        n_min = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (act[i] && cost[i] == min_c) n_min = n_min + 2'd1;
        end

        rr_eff = (rr_q == 2'd3) ? 2'd0 : rr_q;
        found  = 1'b0;
        pick   = 2'd0;
        sum    = 3'd0;
        idx    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, rr_eff} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
            if (!found && act[idx] && cost[idx] == min_c) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        adapt_dir = found ? cand_dir[pick] : DIR_LOCAL;

        if (in_dest.z != POS.z)      det_dir = (in_dest.z > POS.z) ? DIR_UP : DIR_DOWN;
        else if (in_dest.x != POS.x) det_dir = (in_dest.x > POS.x) ? DIR_EAST : DIR_WEST;
        else if (in_dest.y != POS.y) det_dir = (in_dest.y > POS.y) ? DIR_NORTH : DIR_SOUTH;
        else                         det_dir = DIR_LOCAL;

        sel_dir = adaptive_en ? adapt_dir : det_dir;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_dir_d   = out_dir_q;
        out_dest_d  = out_dest_q;
        rr_d        = rr_q;
        stat_d      = stat_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_dir_d   = sel_dir;
            out_dest_d  = in_dest;
            if (adaptive_en && n_min >= 2'd2) rr_d = (rr_eff == 2'd2) ? 2'd0 : rr_eff + 2'd1;
            if (adaptive_en && adapt_dir != det_dir && stat_q != '1) stat_d = stat_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_dir_q   <= DIR_LOCAL;
            out_dest_q  <= '0;
            rr_q        <= 2'd0;
            stat_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_dir_q   <= out_dir_d;
            out_dest_q  <= out_dest_d;
            rr_q        <= rr_d;
            stat_q      <= stat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_dir    = out_dir_q;
    assign out_dest   = out_dest_q;
    assign stat_adapt = stat_q;
    assign dbg_rr     = rr_q;
endmodule

// File: tb/tb_rcu_adaptive.sv
// Directed plus randomized bench for rcu_adaptive at POS={1,1,1}, STAT_W=4, against a
// list-based routing model and a transaction-level output-register model.
module tb_rcu_adaptive;
    import rcu_adaptive_pkg::*;

    localparam pos_t P = '{x: 4'd1, y: 4'd1, z: 4'd1};

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    pos_t            in_dest;
    logic            adaptive_en;
    logic [5:0][3:0] cong;
    logic            out_valid;
    logic            out_ready;
    dir_t            out_dir;
    pos_t            out_dest;
    logic [3:0]      stat_adapt;
    logic [1:0]      dbg_rr;

    int vectors = 0;
    int miscompares = 0;

    // Expected state of the result register and bookkeeping.
    logic exp_valid = 1'b0;
    dir_t exp_dir   = DIR_LOCAL;
    pos_t exp_dest  = '0;
    int   exp_rr    = 0;
    int   exp_stat  = 0;

    rcu_adaptive #(.POS(P), .CONG_W(4), .STAT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .adaptive_en(adaptive_en), .cong(cong),
        .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
        .out_dest(out_dest), .stat_adapt(stat_adapt), .dbg_rr(dbg_rr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference routing: list the candidates of the active phase in tie-break order
    // (Z, X, Y rotated to start at rr), take the first with the lowest congestion.
    function automatic void ref_route(input pos_t d, input logic [5:0][3:0] c, input int rr,
                                      output dir_t adir, output dir_t ddir, output int ties);
        dir_t neg_d[3] = '{DIR_DOWN, DIR_WEST, DIR_SOUTH};
        dir_t pos_d[3] = '{DIR_UP, DIR_EAST, DIR_NORTH};
        int   dd[3]    = '{int'(d.z), int'(d.x), int'(d.y)};
        int   pp[3]    = '{int'(P.z), int'(P.x), int'(P.y)};
        dir_t lst[$];
        int   best;
        lst = {};
        for (int k = 0; k < 3; k++) if (dd[(rr + k) % 3] < pp[(rr + k) % 3]) lst.push_back(neg_d[(rr + k) % 3]);
        if (lst.size() == 0)
            for (int k = 0; k < 3; k++) if (dd[(rr + k) % 3] > pp[(rr + k) % 3]) lst.push_back(pos_d[(rr + k) % 3]);
        adir = DIR_LOCAL;
        ties = 0;
        best = 99;
        foreach (lst[i]) if (int'(c[int'(lst[i])]) < best) begin best = int'(c[int'(lst[i])]); adir = lst[i]; end
        foreach (lst[i]) if (int'(c[int'(lst[i])]) == best) ties++;
        ddir = DIR_LOCAL;
        for (int k = 2; k >= 0; k--)
            if (dd[k] != pp[k]) ddir = (dd[k] > pp[k]) ? pos_d[k] : neg_d[k];
    endfunction

    task automatic step(input logic r, input logic v, input logic ordy, input logic en,
                        input pos_t d, input logic [5:0][3:0] c);
        dir_t adir, ddir;
        int   ties;
        logic acc;
        rst = r; in_valid = v; out_ready = ordy; adaptive_en = en; in_dest = d; cong = c;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
        acc = v && (!exp_valid || ordy);
        if (r) begin
            exp_valid = 1'b0; exp_dir = DIR_LOCAL; exp_dest = '0; exp_rr = 0; exp_stat = 0;
        end else if (acc) begin
            ref_route(d, c, exp_rr, adir, ddir, ties);
            exp_dir   = en ? adir : ddir;
            exp_dest  = d;
            exp_valid = 1'b1;
            if (en && ties >= 2) exp_rr = (exp_rr + 1) % 3;
            if (en && adir != ddir && exp_stat < 15) exp_stat++;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_dir", 32'(out_dir), 32'(exp_dir));
        chk("out_dest", 32'(out_dest), 32'(exp_dest));
        chk("stat_adapt", 32'(stat_adapt), 32'(exp_stat));
        chk("rr", 32'(dbg_rr), 32'(exp_rr));
    endtask

    function automatic pos_t mk(input int x, input int y, input int z);
        pos_t p;
        p.x = 4'(x); p.y = 4'(y); p.z = 4'(z);
        return p;
    endfunction

    function automatic logic [5:0][3:0] rnd_cong();
        logic [5:0][3:0] c;
        for (int i = 0; i < 6; i++) c[i] = 4'($urandom_range(0, 15));
        return c;
    endfunction

    initial begin
        logic [5:0][3:0] c7, c0, c34;
        c7  = {6{4'd7}};
        c0  = '0;
        c34 = c7;
        c34[int'(DIR_WEST)]  = 4'd5;
        c34[int'(DIR_SOUTH)] = 4'd3;

        // Reset, then the idle state after release.
        step(1, 0, 1, 0, mk(0, 0, 0), c7);
        step(1, 1, 1, 0, mk(2, 2, 2), c7);
        chk("reset_dir_local", 32'(out_dir), 32'(DIR_LOCAL));

        // Deterministic routes.
        step(0, 1, 1, 0, mk(2, 0, 1), c7);
        chk("det_east", 32'(out_dir), 32'(DIR_EAST));
        step(0, 1, 1, 0, mk(1, 1, 0), c7);
        chk("det_down", 32'(out_dir), 32'(DIR_DOWN));
        step(0, 1, 1, 0, mk(1, 1, 1), c7);
        chk("det_local", 32'(out_dir), 32'(DIR_LOCAL));

        // Negative phase wins over UP; lowest congestion picked.
        step(0, 1, 1, 1, mk(0, 0, 2), c34);
        chk("neg_south", 32'(out_dir), 32'(DIR_SOUTH));
        chk("neg_stat", 32'(stat_adapt), 32'd1);

        // Three-way tie rotates through Z, X, Y.
        step(0, 1, 1, 1, mk(2, 2, 2), c0);
        chk("tie_up", 32'(out_dir), 32'(DIR_UP));
        step(0, 1, 1, 1, mk(2, 2, 2), c0);
        chk("tie_east", 32'(out_dir), 32'(DIR_EAST));
        step(0, 1, 1, 1, mk(2, 2, 2), c0);
        chk("tie_north", 32'(out_dir), 32'(DIR_NORTH));
        chk("tie_rr_wrap", 32'(dbg_rr), 32'd0);

        // Back-pressure: result held while inputs churn, then no-bubble resume.
        step(0, 1, 1, 0, mk(2, 0, 1), c7);
        for (int i = 0; i < 4; i++) step(0, 1, 0, i[0], mk(0, 0, 0), rnd_cong());
        chk("hold_dir", 32'(out_dir), 32'(DIR_EAST));
        step(0, 1, 1, 0, mk(1, 1, 0), c7);
        chk("resume_dir", 32'(out_dir), 32'(DIR_DOWN));
        step(0, 1, 1, 0, mk(1, 2, 1), c7);
        chk("b2b_dir", 32'(out_dir), 32'(DIR_NORTH));

        // Randomized traffic; drives stat_adapt into saturation.
        for (int i = 0; i < 400; i++)
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2)), rnd_cong());
        chk("stat_saturated", 32'(stat_adapt), 32'd15);

        // Reset with a held result and a pending request.
        step(0, 1, 0, 1, mk(2, 2, 2), c0);
        step(1, 1, 0, 1, mk(0, 2, 2), c0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_dir", 32'(out_dir), 32'(DIR_LOCAL));
        chk("rst_rr", 32'(dbg_rr), 32'd0);
        step(0, 0, 0, 0, mk(0, 0, 0), c7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
